udma_sdio_cmd_ctrl: RTL and testbench

// - SD CMD-line engine; sits directly downstream of the SDIO register file.
// - On start_i, serialises a 48-bit command frame with generated CRC7 and waits for the response.
// - Captures a 48-bit or 136-bit response, checks it, then reports the outcome.
// - eot/err/status feed back to the register file for the EOT/ERR interrupts and the STATUS register.

---
 rtl/udma_sdio_pkg.sv | 22 ++
 rtl/udma_sdio_crc7.sv | 35 +++
 rtl/udma_sdio_cmd_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_udma_sdio_cmd_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udma_sdio_pkg.sv
// SDIO command-path shared types and constants.
// Response encoding, status bit positions and frame lengths.
package udma_sdio_pkg;

    typedef enum logic [2:0] {
        RSP_NONE = 3'd0,
        RSP_R1   = 3'd1,
        RSP_R2   = 3'd2,
        RSP_R3   = 3'd3,
        RSP_R1B  = 3'd4
    } rsp_type_e;

    localparam int ST_TIMEOUT = 0;
    localparam int ST_CRC     = 1;
    localparam int ST_END     = 2;
    localparam int ST_INVALID = 3;

    localparam int CMD_LEN   = 48;
    localparam int RSP_SHORT = 48;
    localparam int RSP_LONG  = 136;

endpackage

// File: rtl/udma_sdio_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), MSB-first, seeded with zero.
// clr_i has priority over en_i.
module udma_sdio_crc7 (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       bit_i,
    output logic [6:0] crc_o
);

    logic [6:0] crc_q;
    logic [6:0] crc_d;
    logic       fb;

    // Next CRC: clear, shift one bit in, or hold
    always_comb begin
        crc_d = crc_q;
        fb    = crc_q[6] ^ bit_i;
        if (clr_i) begin
            crc_d = '0;
        end else if (en_i) begin
            crc_d = {crc_q[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
    end

    // CRC register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) crc_q <= '0;
        else         crc_q <= crc_d;
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/udma_sdio_cmd_ctrl.sv
// SD CMD-line engine: sends a 48-bit command with CRC7,
// captures and checks the response, reports eot/err/status.
module udma_sdio_cmd_ctrl
    import udma_sdio_pkg::*;
#(
    parameter int RSP_TIMEOUT = 64,
    parameter int NCC_CYCLES  = 8
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         start_i,
    input  logic [5:0]   cmd_op_i,
    input  logic [31:0]  cmd_arg_i,
    input  logic [2:0]   cmd_rsp_type_i,
    output logic         cmd_o,
    output logic         cmd_oen_o,
    input  logic         cmd_i,
    output logic [127:0] rsp_data_o,
    output logic         busy_o,
    output logic         eot_o,
    output logic         err_o,
    output logic [15:0]  status_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_TX, S_TURN, S_WAIT_RSP,
        S_RX, S_CHECK, S_NCC, S_DONE
    } state_e;

    state_e         state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [15:0]    tmo_q, tmo_d;
    logic [39:0]    tx_sr_q, tx_sr_d;
    logic [135:0]   rx_sr_q, rx_sr_d;
    logic [2:0]     rsp_type_q, rsp_type_d;
    logic [3:0]     status_q, status_d;
    logic [127:0]   rsp_data_q, rsp_data_d;

    logic           crc_clr;
    logic           tx_crc_en;
    logic           rx_crc_en;
    logic [6:0]     tx_crc;
    logic [6:0]     rx_crc;
    logic           rx_long;
    logic [7:0]     rx_last;

    udma_sdio_crc7 u_tx_crc (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clr_i  (crc_clr),
        .en_i   (tx_crc_en),
        .bit_i  (tx_sr_q[39]),
        .crc_o  (tx_crc)
    );

    udma_sdio_crc7 u_rx_crc (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clr_i  (crc_clr),
        .en_i   (rx_crc_en),
        .bit_i  (cmd_i),
        .crc_o  (rx_crc)
    );

    assign rx_long = (rsp_type_q == RSP_R2);
    assign rx_last = rx_long ? 8'(RSP_LONG - 1) : 8'(RSP_SHORT - 1);

    // Next-state logic, datapath updates and CMD-line outputs
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rsp_type_d = rsp_type_q;
        status_d   = status_q;
        rsp_data_d = rsp_data_q;
        crc_clr    = 1'b0;
        tx_crc_en  = 1'b0;
        rx_crc_en  = 1'b0;
        cmd_o      = 1'b1;
        cmd_oen_o  = 1'b1;
        busy_o     = 1'b1;
        eot_o      = 1'b0;
        err_o      = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                busy_o = 1'b0;
                if (state_q == S_DONE) begin
                    eot_o   = (status_q == 4'd0);
                    err_o   = (status_q != 4'd0);
                    state_d = S_IDLE;
                end
                if (start_i) begin
                    tx_sr_d    = {2'b01, cmd_op_i, cmd_arg_i};
                    rsp_type_d = cmd_rsp_type_i;
                    status_d   = '0;
                    cnt_d      = '0;
                    rx_sr_d    = '0;
                    crc_clr    = 1'b1;
                    if (cmd_rsp_type_i > RSP_R1B) begin
                        status_d[ST_INVALID] = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_TX;
                    end
                end
            end
            S_TX: begin
                cmd_oen_o = 1'b0;
                cnt_d     = cnt_q + 8'd1;
                if (cnt_q < 8'd40) begin
                    cmd_o     = tx_sr_q[39];
                    tx_sr_d   = tx_sr_q << 1;
                    tx_crc_en = 1'b1;
                end else if (cnt_q < 8'd47) begin
                    cmd_o = tx_crc[3'd6 - cnt_q[2:0]];
                end
                if (cnt_q == 8'(CMD_LEN - 1)) begin
                    cnt_d   = '0;
                    tmo_d   = '0;
                    state_d = (rsp_type_q == RSP_NONE) ? S_NCC : S_TURN;
                end
            end
            S_TURN: begin
                tmo_d = tmo_q + 16'd1;
                if (tmo_q == 16'd1) state_d = S_WAIT_RSP;
            end
            S_WAIT_RSP: begin
                tmo_d = tmo_q + 16'd1;
                if (!cmd_i) begin
                    rx_sr_d   = (rx_sr_q << 1) | 136'(cmd_i);
                    rx_crc_en = !rx_long;
                    cnt_d     = 8'd1;
                    state_d   = S_RX;
                end else if (tmo_q == 16'(RSP_TIMEOUT - 1)) begin
                    status_d[ST_TIMEOUT] = 1'b1;
                    cnt_d   = '0;
                    state_d = S_NCC;
                end
            end
            S_RX: begin
                rx_sr_d = (rx_sr_q << 1) | 136'(cmd_i);
                cnt_d   = cnt_q + 8'd1;
                if (rx_long) rx_crc_en = (cnt_q >= 8'd8) && (cnt_q < 8'd128);
                else         rx_crc_en = (cnt_q < 8'd40);
                if (cnt_q == rx_last) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (rx_long) begin
                    rsp_data_d = rx_sr_q[127:0];
                end else begin
                    rsp_data_d        = '0;
                    rsp_data_d[31:0]  = rx_sr_q[39:8];
                    rsp_data_d[37:32] = rx_sr_q[45:40];
                end
                if (!rx_sr_q[0]) status_d[ST_END] = 1'b1;
                if (rsp_type_q != RSP_R3 && rx_crc != rx_sr_q[7:1])
                    status_d[ST_CRC] = 1'b1;
                cnt_d   = '0;
                state_d = S_NCC;
            end
            S_NCC: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'(NCC_CYCLES - 1)) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            tmo_q      <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rsp_type_q <= '0;
            status_q   <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rsp_type_q <= rsp_type_d;
            status_q   <= status_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign rsp_data_o = rsp_data_q;
    assign status_o   = {12'd0, status_q};

endmodule

// File: tb/tb_udma_sdio_cmd_ctrl.sv
// Bench for udma_sdio_cmd_ctrl: directed and randomized
// command/response transactions against a frame-level model.
module tb_udma_sdio_cmd_ctrl;

    localparam int RSP_TIMEOUT = 64;
    localparam int NCC_CYCLES  = 8;

    logic         clk_i = 1'b0;
    logic         rstn_i;
    logic         start_i;
    logic [5:0]   cmd_op_i;
    logic [31:0]  cmd_arg_i;
    logic [2:0]   cmd_rsp_type_i;
    logic         cmd_o;
    logic         cmd_oen_o;
    logic         cmd_i;
    logic [127:0] rsp_data_o;
    logic         busy_o;
    logic         eot_o;
    logic         err_o;
    logic [15:0]  status_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [127:0] exp_rsp;

    udma_sdio_cmd_ctrl #(
        .RSP_TIMEOUT (RSP_TIMEOUT),
        .NCC_CYCLES  (NCC_CYCLES)
    ) dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .start_i        (start_i),
        .cmd_op_i       (cmd_op_i),
        .cmd_arg_i      (cmd_arg_i),
        .cmd_rsp_type_i (cmd_rsp_type_i),
        .cmd_o          (cmd_o),
        .cmd_oen_o      (cmd_oen_o),
        .cmd_i          (cmd_i),
        .rsp_data_o     (rsp_data_o),
        .busy_o         (busy_o),
        .eot_o          (eot_o),
        .err_o          (err_o),
        .status_o       (status_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [135:0] obs,
                         input logic [135:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // CRC7 as polynomial division of bits v[hi..lo], MSB first
    function automatic logic [6:0] crc7(input logic [135:0] v,
                                        input int hi, input int lo);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = hi; i >= lo; i--) begin
            fb = c[6] ^ v[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [47:0] mk_cmd(input logic [5:0] op,
                                           input logic [31:0] arg);
        logic [135:0] f;
        f = '0;
        f[47:8] = {2'b01, op, arg};
        f[7:1]  = crc7(f, 47, 8);
        f[0]    = 1'b1;
        return f[47:0];
    endfunction

    function automatic logic [135:0] mk_short(input logic [5:0] idx,
            input logic [31:0] pl, input logic flip, input int fb,
            input logic bend);
        logic [135:0] f;
        f = '0;
        f[47:8] = {2'b00, idx, pl};
        f[7:1]  = crc7(f, 47, 8);
        f[0]    = !bend;
        if (flip) f[fb] = ~f[fb];
        return f;
    endfunction

    function automatic logic [135:0] mk_long(input logic [119:0] pl,
            input logic flip, input int fb, input logic bend);
        logic [135:0] f;
        f = '0;
        f[135:8] = {8'h3F, pl};
        f[7:1]   = crc7(f, 127, 8);
        f[0]     = !bend;
        if (flip) f[fb] = ~f[fb];
        return f;
    endfunction

    // One transaction: start, capture CMD frame, answer as a card
    task automatic run_txn(input logic [5:0] op, input logic [31:0] arg,
            input logic [2:0] typ, input logic [135:0] rf, input int rlen,
            input int dly, input int glitch, input int rst_at,
            output logic [47:0] got);
        logic [47:0] exp_f;
        logic [3:0]  exp_st;
        logic        oen_bad;
        logic [6:0]  c;
        int          cyc;
        int          exp_cyc;
        int          lim;
        exp_f = mk_cmd(op, arg);
        @(negedge clk_i);
        start_i = 1'b1; cmd_op_i = op;
        cmd_arg_i = arg; cmd_rsp_type_i = typ;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        cyc = 1; oen_bad = 1'b0; got = '0;
        for (int k = 1; k <= 48; k++) begin
            got[48-k] = cmd_o;
            if (cmd_oen_o !== 1'b0) oen_bad = 1'b1;
            if (k == rst_at) begin
                rstn_i = 1'b0;
                #1;
                check("rst_oen", 136'(cmd_oen_o), 136'(1));
                check("rst_busy", 136'(busy_o), 136'(0));
                exp_rsp = '0;
                @(posedge clk_i); #1;
                rstn_i = 1'b1;
                return;
            end
            start_i = (k == glitch);
            if (k == glitch) begin
                cmd_op_i = ~op; cmd_arg_i = ~arg; cmd_rsp_type_i = 3'd0;
            end
            @(posedge clk_i); #1;
            cyc++;
        end
        start_i = 1'b0;
        check("tx_frame", 136'(got), 136'(exp_f));
        check("tx_oen", 136'(oen_bad), 136'(0));
        exp_st = '0;
        if (typ == 3'd0) begin
            exp_cyc = 48 + NCC_CYCLES + 1;
        end else if (rlen == 0) begin
            exp_st[0] = 1'b1;
            exp_cyc = 48 + RSP_TIMEOUT + NCC_CYCLES + 1;
        end else begin
            repeat (dly) begin @(posedge clk_i); #1; cyc++; end
            for (int i = rlen - 1; i >= 0; i--) begin
                cmd_i = rf[i];
                @(posedge clk_i); #1;
                cyc++;
            end
            cmd_i = 1'b1;
            exp_cyc = cyc + NCC_CYCLES + 1;
            if (!rf[0]) exp_st[2] = 1'b1;
            if (rlen == 48) c = crc7(rf, 47, 8);
            else            c = crc7(rf, 127, 8);
            if (typ != 3'd3 && c != rf[7:1]) exp_st[1] = 1'b1;
            if (rlen == 48) exp_rsp = {90'd0, rf[45:40], rf[39:8]};
            else            exp_rsp = rf[127:0];
        end
        lim = cyc + 400;
        while (eot_o !== 1'b1 && err_o !== 1'b1 && cyc < lim) begin
            @(posedge clk_i); #1;
            cyc++;
        end
        check("done_cyc", 136'(cyc), 136'(exp_cyc));
        check("eot", 136'(eot_o), 136'(exp_st == 4'd0));
        check("err", 136'(err_o), 136'(exp_st != 4'd0));
        check("status", 136'(status_o), 136'(exp_st));
        check("rsp_data", 136'(rsp_data_o), 136'(exp_rsp));
        @(posedge clk_i); #1;
        check("idle_busy", 136'(busy_o), 136'(0));
        check("status_hold", 136'(status_o), 136'(exp_st));
    endtask

    initial begin
        logic [47:0]  got;
        logic [135:0] rf;
        logic [2:0]   typ;
        logic [5:0]   op;
        logic [31:0]  arg;
        logic [127:0] pl;
        int           flt;
        int           lim;
        rstn_i = 1'b0; start_i = 1'b0; cmd_i = 1'b1;
        cmd_op_i = '0; cmd_arg_i = '0; cmd_rsp_type_i = '0;
        exp_rsp = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_oen", 136'(cmd_oen_o), 136'(1));
        check("rst_cmd", 136'(cmd_o), 136'(1));
        check("rst_busy", 136'(busy_o), 136'(0));
        check("rst_eot_err", 136'({eot_o, err_o}), 136'(0));
        check("rst_status", 136'(status_o), 136'(0));
        check("rst_rsp", 136'(rsp_data_o), 136'(0));
        rstn_i = 1'b1;

        // CMD0, no response
        run_txn(6'd0, 32'h0, 3'd0, '0, 0, 0, 0, 0, got);
        check("cmd0_frame", 136'(got), 136'(48'h40_0000_0000_95));

        // CMD8 with known R1 answer
        rf = {88'd0, 48'h08_0000_01AA_13};
        run_txn(6'd8, 32'h1AA, 3'd1, rf, 48, 4, 0, 0, got);
        check("cmd8_frame", 136'(got), 136'(48'h48_0000_01AA_87));
        check("cmd8_rsp", 136'(rsp_data_o[31:0]), 136'(32'h1AA));

        // CMD17 with no card answer
        run_txn(6'd17, 32'h1234, 3'd1, '0, 0, 0, 0, 0, got);

        // CRC flip and bad end bit on R1
        rf = mk_short(6'd17, 32'h900, 1'b1, 3, 1'b0);
        run_txn(6'd17, 32'h55, 3'd1, rf, 48, 2, 0, 0, got);
        rf = mk_short(6'd17, 32'h900, 1'b0, 0, 1'b1);
        run_txn(6'd17, 32'h55, 3'd1, rf, 48, 7, 0, 0, got);

        // CMD2 with a 136-bit CID
        pl = {$urandom, $urandom, $urandom, $urandom};
        rf = mk_long(pl[119:0], 1'b0, 0, 1'b0);
        run_txn(6'd2, 32'h0, 3'd2, rf, 136, 3, 0, 0, got);

        // start during TX is ignored
        rf = mk_short(6'd13, $urandom, 1'b0, 0, 1'b0);
        run_txn(6'd13, $urandom, 3'd1, rf, 48, 5, 20, 0, got);

        // reset mid-frame, then a normal command
        run_txn(6'd24, $urandom, 3'd1, '0, 0, 0, 0, 30, got);
        check("post_rst_rsp", 136'(rsp_data_o), 136'(0));
        rf = mk_short(6'd55, $urandom, 1'b0, 0, 1'b0);
        run_txn(6'd55, $urandom, 3'd4, rf, 48, 2, 0, 0, got);

        // invalid type, then start accepted in the DONE cycle
        @(negedge clk_i);
        start_i = 1'b1; cmd_rsp_type_i = 3'd6; cmd_op_i = 6'd1;
        @(posedge clk_i); #1;
        check("inv_err", 136'({eot_o, err_o}), 136'(2'b01));
        check("inv_status", 136'(status_o), 136'(16'h0008));
        check("inv_oen", 136'(cmd_oen_o), 136'(1));
        check("inv_busy", 136'(busy_o), 136'(0));
        cmd_rsp_type_i = 3'd0;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        check("done_start_busy", 136'(busy_o), 136'(1));
        check("done_start_oen", 136'(cmd_oen_o), 136'(0));
        lim = 0;
        while (eot_o !== 1'b1 && err_o !== 1'b1 && lim < 200) begin
            @(posedge clk_i); #1;
            lim++;
        end
        check("done_start_eot", 136'({eot_o, err_o, status_o}),
              136'({2'b10, 16'h0}));
        @(posedge clk_i); #1;

        // randomized transactions
        for (int t = 0; t < 12; t++) begin
            typ = 3'($urandom_range(1, 4));
            flt = $urandom_range(0, 3);
            op  = 6'($urandom);
            arg = $urandom;
            pl  = {$urandom, $urandom, $urandom, $urandom};
            if (typ == 3'd2)
                rf = mk_long(pl[119:0], flt == 1,
                             $urandom_range(1, 7), flt == 2);
            else
                rf = mk_short((typ == 3'd3) ? 6'h3F : op, pl[31:0],
                              flt == 1, $urandom_range(1, 7), flt == 2);
            run_txn(op, arg, typ, rf,
                    (flt == 3) ? 0 : ((typ == 3'd2) ? 136 : 48),
                    $urandom_range(2, 30), 0, 0, got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
